bwt_axil_cmd_master: RTL and testbench
======================================

Name: bwt_axil_cmd_master

Overview:
- AXI4-Lite master that turns a simple command stream (single read or write) into bus transactions toward the bwt_ip S00_AXI register slave.
- Sits directly upstream of bwt_ip. Replaces the verification-IP master in hardware, so a local sequencer or PL controller can program and poll the BWT registers.
- One transaction outstanding at a time. Each transaction returns exactly one response on the rsp stream.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when the optional feature is compiled in.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- rsp_timeout  out  1  watchdog abort flag; constant 0 without the feature
- M_AXI_AWADDR/AWPROT/AWVALID out, M_AXI_AWREADY in  C_M_AXI_ADDR_WIDTH/3/1/1
- M_AXI_WDATA/WSTRB/WVALID out, M_AXI_WREADY in  32/4/1/1
- M_AXI_BRESP in, M_AXI_BVALID in, M_AXI_BREADY out  2/1/1
- M_AXI_ARADDR/ARPROT/ARVALID out, M_AXI_ARREADY in  C_M_AXI_ADDR_WIDTH/3/1/1
- M_AXI_RDATA/RRESP/RVALID in, M_AXI_RREADY out  32/2/1/1

Behaviour:
- Reset values:
  - All VALID/READY outputs 0, except cmd_ready = 1.
  - All data/addr/resp outputs 0.
  - FSM = IDLE.
- Reset mid-transaction: outputs drop to reset values immediately (asynchronous). The in-flight transaction is discarded and no response is issued.
- AWPROT = ARPROT = 3'b000. Addresses are driven unmodified.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE
  - cmd_ready = 1.
  - On cmd_valid, capture cmd_* into registers.
  - Go to WR if cmd_write = 1, else RD_ADDR.
  - Bus VALIDs rise in the cycle after acceptance.
- WR
  - AWVALID and WVALID both asserted.
  - Each is held until its own READY handshake; track with aw_done and w_done flags.
  - AW and W may complete in the same cycle or in either order.
  - A VALID never deasserts before its READY.
  - When both are done (including same cycle), go to WR_RESP.
- WR_RESP
  - BREADY = 1.
  - On BVALID: latch BRESP, set rsp_rdata = 0, go to RSP.
  - A BVALID that arrives before both AW and W are done is ignored; BREADY is 0 in WR.
- RD_ADDR: ARVALID held until ARREADY, then go to RD_DATA.
- RD_DATA
  - RREADY = 1.
  - On RVALID: latch RDATA and RRESP, go to RSP.
- RSP
  - rsp_valid = 1; rsp_* stay stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - cmd_ready stays 0 until IDLE, so the next command is accepted no earlier than the cycle after the rsp handshake.
- Minimum latency, cmd accept to rsp_valid:
  - Write with zero-wait slave: 3 cycles.
  - Read with zero-wait slave: 3 cycles.
- SLVERR/DECERR responses are passed through on rsp_resp unchanged. No retry.

Optional Feature:
- BWT_AXIL_TIMEOUT_EN defined:
  - A 32-bit counter clears on command acceptance and increments every cycle in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When the counter reaches TIMEOUT_CYCLES, all bus VALID/READY outputs drop and the FSM goes to RSP with rsp_resp = 2'b10, rsp_timeout = 1 and rsp_rdata = 0.
  - This is a fatal-recovery path: the slave must be reset afterwards.
- Not defined: no counter is built, rsp_timeout is tied to 0, and the FSM can wait forever.

Decomposition:
- Package bwt_axil_pkg holds:
  - FSM state enum.
  - AXI response constants: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - Default TIMEOUT_CYCLES.
- No sub-module needed. The optional watchdog may live in the same module under the macro.

Test Plan:
- Write 0x00000001..0x00000004 to 0x0, 0x4, 0x8, 0xC, then read all four back -> four write rsp with resp = OKAY, then read rsp_rdata = 1, 2, 3, 4 with resp = OKAY.
- Write with WREADY asserted 3 cycles before AWREADY, then repeat with AWREADY first -> WVALID and AWVALID each drop the cycle after their own handshake; exactly one BREADY pulse; one rsp.
- Read, with slave returning RRESP = 2'b10 and RDATA = 0xDEADBEEF -> rsp_resp = 2'b10, rsp_rdata = 0xDEADBEEF.
- Hold rsp_ready low for 10 cycles with cmd_valid high -> rsp_* stable; cmd_ready = 0 throughout; the next command is accepted the cycle after the rsp handshake.
- Assert ARESET while AWVALID is high and awaiting AWREADY -> AWVALID and WVALID go low immediately; no rsp_valid; after release, cmd_ready = 1.
- With BWT_AXIL_TIMEOUT_EN and TIMEOUT_CYCLES = 16, issue a read to a slave that never asserts ARREADY -> at 16 cycles ARVALID drops, rsp_valid = 1, rsp_resp = 2'b10, rsp_timeout = 1.

Source files
------------

// File: rtl/bwt_axil_pkg.sv
// Shared types and constants for the bwt_ip AXI4-Lite command master.
package bwt_axil_pkg;

   // Command master transaction sequencing.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RSP
   } state_t;

   // AXI response encodings.
   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_SLVERR = 2'b10;
   localparam logic [1:0] AXI_DECERR = 2'b11;

   // Default watchdog limit in bus-wait cycles.
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/bwt_axil_cmd_master.sv
// AXI4-Lite master: one read or write command in, one bus transaction out,
// one response back. One transaction outstanding at a time.
// Optional watchdog abort compiled in with BWT_AXIL_TIMEOUT_EN.
module bwt_axil_cmd_master
   import bwt_axil_pkg::*;
#(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_write,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            rsp_timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);

   state_t                            state;
   state_t                            state_nxt;
   logic                              aw_done;
   logic                              w_done;
   logic                              write_q;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]     rdata_q;
   logic [1:0]                        resp_q;
   logic                              tmo_hit;
   logic                              accept;

   assign accept = (state == ST_IDLE) && cmd_valid;

   // State register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a watchdog expiry overrides any pending bus wait.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:    if (cmd_valid) state_nxt = cmd_write ? ST_WR : ST_RD_ADDR;
         ST_WR:      if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
                        state_nxt = ST_WR_RESP;
         ST_WR_RESP: if (M_AXI_BVALID)  state_nxt = ST_RSP;
         ST_RD_ADDR: if (M_AXI_ARREADY) state_nxt = ST_RD_DATA;
         ST_RD_DATA: if (M_AXI_RVALID)  state_nxt = ST_RSP;
         ST_RSP:     if (rsp_ready)     state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
      if (tmo_hit) state_nxt = ST_RSP;
   end

   // Command capture, AW/W completion tracking and response latching.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         resp_q  <= AXI_OKAY;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  write_q <= cmd_write;
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
               end
            end
            ST_WR: begin
               if (M_AXI_AWREADY) aw_done <= 1'b1;
               if (M_AXI_WREADY)  w_done  <= 1'b1;
            end
            ST_WR_RESP: begin
               if (M_AXI_BVALID) begin
                  resp_q  <= M_AXI_BRESP;
                  rdata_q <= '0;
               end
            end
            ST_RD_DATA: begin
               if (M_AXI_RVALID) begin
                  resp_q  <= M_AXI_RRESP;
                  rdata_q <= M_AXI_RDATA;
               end
            end
            default: ;
         endcase
         if (tmo_hit) begin
            resp_q  <= AXI_SLVERR;
            rdata_q <= '0;
         end
      end
   end

`ifdef BWT_AXIL_TIMEOUT_EN
   logic [31:0] tmo_cnt;
   logic        tmo_q;
   logic        bus_wait;

   assign bus_wait = (state == ST_WR) || (state == ST_WR_RESP) ||
                     (state == ST_RD_ADDR) || (state == ST_RD_DATA);
   assign tmo_hit  = bus_wait && (tmo_cnt >= TIMEOUT_CYCLES - 1);

   // Watchdog: counts cycles spent waiting on the bus since acceptance.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         tmo_cnt <= '0;
         tmo_q   <= 1'b0;
      end else begin
         if (accept) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
         end else if (bus_wait) begin
            tmo_cnt <= tmo_cnt + 32'd1;
         end
         if (tmo_hit) tmo_q <= 1'b1;
      end
   end

   assign rsp_timeout = tmo_q;
`else
   assign tmo_hit     = 1'b0;
   assign rsp_timeout = 1'b0;

   // The watchdog limit only has meaning when the watchdog is built in.
   if (TIMEOUT_CYCLES == 0) begin : g_tmo_cfg
   end
`endif

   assign cmd_ready     = (state == ST_IDLE);
   assign rsp_valid     = (state == ST_RSP);
   assign rsp_write     = write_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = (state == ST_WR) && !aw_done;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = (state == ST_WR) && !w_done;
   assign M_AXI_BREADY  = (state == ST_WR_RESP);
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = (state == ST_RD_ADDR);
   assign M_AXI_RREADY  = (state == ST_RD_DATA);

endmodule

// File: tb/tb_bwt_axil_cmd_master.sv
// Self-checking bench for bwt_axil_cmd_master with a small AXI4-Lite slave
// model (4-word memory, programmable ready latencies and error injection).
module tb_bwt_axil_cmd_master;

   logic        clk = 1'b0;
   logic        ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bwt_axil_cmd_master #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .ACLK(clk), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   // ---------------- slave model ----------------
   int          k_aw_lat = 0, k_w_lat = 0;
   logic        k_ar_stall = 1'b0, k_err_en = 1'b0;
   logic [1:0]  k_err = 2'b00;
   logic [31:0] mem [4];
   logic        got_aw, got_w, got_ar, hs_aw, hs_w, hs_b, hs_ar, hs_r;
   int          aw_wait, w_wait;
   logic [31:0] cap_waddr, cap_wdata, cap_raddr;
   logic [3:0]  cap_wstrb;

   // Slave drives its outputs at the falling edge; handshakes complete on the next rising edge.
   always @(negedge clk) begin
      if (ARESET) begin
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
         M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
         got_aw = 0; got_w = 0; got_ar = 0;
         hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
         aw_wait = 0; w_wait = 0;
         cap_waddr = 0; cap_wdata = 0; cap_wstrb = 0; cap_raddr = 0;
      end else begin
         if (hs_aw) got_aw = 1;
         if (hs_w)  got_w  = 1;
         if (hs_ar) got_ar = 1;
         if (hs_r)  got_ar = 0;
         if (hs_b) begin
            for (int b = 0; b < 4; b++)
               if (cap_wstrb[b]) mem[cap_waddr[3:2]][8*b +: 8] = cap_wdata[8*b +: 8];
            got_aw = 0; got_w = 0;
         end
         if (M_AXI_AWVALID && !got_aw) begin
            M_AXI_AWREADY = (aw_wait >= k_aw_lat);
            aw_wait++;
            if (M_AXI_AWREADY) cap_waddr = M_AXI_AWADDR;
         end else begin
            M_AXI_AWREADY = 0; aw_wait = 0;
         end
         if (M_AXI_WVALID && !got_w) begin
            M_AXI_WREADY = (w_wait >= k_w_lat);
            w_wait++;
            if (M_AXI_WREADY) begin cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB; end
         end else begin
            M_AXI_WREADY = 0; w_wait = 0;
         end
         M_AXI_BVALID  = got_aw && got_w;
         M_AXI_BRESP   = k_err_en ? k_err : 2'b00;
         M_AXI_ARREADY = M_AXI_ARVALID && !got_ar && !k_ar_stall;
         if (M_AXI_ARREADY) cap_raddr = M_AXI_ARADDR;
         M_AXI_RVALID  = got_ar;
         M_AXI_RDATA   = k_err_en ? 32'hDEADBEEF : mem[cap_raddr[3:2]];
         M_AXI_RRESP   = k_err_en ? k_err : 2'b00;
         hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
         hs_w  = M_AXI_WVALID  && M_AXI_WREADY;
         hs_b  = M_AXI_BVALID  && M_AXI_BREADY;
         hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
         hs_r  = M_AXI_RVALID  && M_AXI_RREADY;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   int          r_lat, br_cnt;
   logic [31:0] r_rdata, tr_aw, tr_w, tr_ar;
   logic [1:0]  r_resp;
   logic        r_write, r_tmo, r_after_valid;

   task automatic sample_cycle();
      if (r_lat < 32) begin
         tr_aw[r_lat] = M_AXI_AWVALID;
         tr_w[r_lat]  = M_AXI_WVALID;
         tr_ar[r_lat] = M_AXI_ARVALID;
      end
      if (M_AXI_BREADY) br_cnt++;
   endtask

   // One full command: offer, wait (bounded) for the response, consume it.
   task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st);
      tr_aw = '0; tr_w = '0; tr_ar = '0; br_cnt = 0;
      @(negedge clk);
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
      @(negedge clk);
      cmd_valid = 0;
      r_lat = 1;
      sample_cycle();
      while (!rsp_valid && r_lat < 200) begin
         @(negedge clk);
         r_lat++;
         sample_cycle();
      end
      r_rdata = rsp_rdata; r_resp = rsp_resp; r_write = rsp_write; r_tmo = rsp_timeout;
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      r_after_valid = rsp_valid;
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        err_en;
      logic [1:0]  err;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
   } vec_t;

   vec_t vt[12];

   // ---------------- stimulus ----------------
   initial begin
      int n;
      ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
      rsp_ready = 0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h0;

      vt[0]  = '{1'b1, 32'h0, 32'h1,        4'hF, 1'b0, 2'b00, 32'h0,        2'b00, 3};
      vt[1]  = '{1'b1, 32'h4, 32'h2,        4'hF, 1'b0, 2'b00, 32'h0,        2'b00, 3};
      vt[2]  = '{1'b1, 32'h8, 32'h3,        4'hF, 1'b0, 2'b00, 32'h0,        2'b00, 3};
      vt[3]  = '{1'b1, 32'hC, 32'h4,        4'hF, 1'b0, 2'b00, 32'h0,        2'b00, 3};
      vt[4]  = '{1'b0, 32'h0, 32'hFFFF0000, 4'h0, 1'b0, 2'b00, 32'h1,        2'b00, 3};
      vt[5]  = '{1'b0, 32'h4, 32'h0,        4'h0, 1'b0, 2'b00, 32'h2,        2'b00, 3};
      vt[6]  = '{1'b0, 32'h8, 32'h0,        4'h0, 1'b0, 2'b00, 32'h3,        2'b00, 3};
      vt[7]  = '{1'b0, 32'hC, 32'h0,        4'h0, 1'b0, 2'b00, 32'h4,        2'b00, 3};
      vt[8]  = '{1'b1, 32'h4, 32'hAABBCCDD, 4'h5, 1'b0, 2'b00, 32'h0,        2'b00, 3};
      vt[9]  = '{1'b0, 32'h4, 32'h0,        4'h0, 1'b0, 2'b00, 32'h00BB00DD, 2'b00, 3};
      vt[10] = '{1'b0, 32'hC, 32'h0,        4'h0, 1'b1, 2'b10, 32'hDEADBEEF, 2'b10, 3};
      vt[11] = '{1'b1, 32'h0, 32'h12345678, 4'h0, 1'b1, 2'b11, 32'h0,        2'b11, 3};

      repeat (3) @(negedge clk);
      check("reset_flags", {cmd_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                            M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, rsp_timeout}, 8'b1000_0000);
      check("reset_addr", {M_AXI_AWADDR, M_AXI_ARADDR}, 64'h0);
      check("reset_rsp", {rsp_rdata, rsp_resp, rsp_write}, 64'h0);
      check("reset_wdata", {M_AXI_WDATA, M_AXI_WSTRB, M_AXI_AWPROT, M_AXI_ARPROT}, 64'h0);
      ARESET = 0;
      @(negedge clk);
      check("idle_cmd_ready", cmd_ready, 1);

      // Table-driven transactions.
      for (int i = 0; i < 12; i++) begin
         k_err_en = vt[i].err_en; k_err = vt[i].err;
         do_cmd(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb);
         check($sformatf("vec%0d_rdata", i), r_rdata, vt[i].exp_rdata);
         check($sformatf("vec%0d_resp", i), r_resp, vt[i].exp_resp);
         check($sformatf("vec%0d_write", i), r_write, vt[i].wr);
         check($sformatf("vec%0d_timeout", i), r_tmo, 0);
         check($sformatf("vec%0d_latency", i), r_lat, vt[i].exp_lat);
         check($sformatf("vec%0d_rsp_drop", i), r_after_valid, 0);
      end
      k_err_en = 0; k_err = 0;

      // W accepted three cycles before AW.
      k_aw_lat = 3; k_w_lat = 0;
      do_cmd(1'b1, 32'h0, 32'h1, 4'hF);
      check("wfirst_awvalid", tr_aw[5:1], 5'b01111);
      check("wfirst_wvalid", tr_w[5:1], 5'b00001);
      check("wfirst_bready", br_cnt, 1);
      check("wfirst_latency", r_lat, 6);
      check("wfirst_one_rsp", r_after_valid, 0);

      // AW accepted three cycles before W.
      k_aw_lat = 0; k_w_lat = 3;
      do_cmd(1'b1, 32'h0, 32'h1, 4'hF);
      check("awfirst_awvalid", tr_aw[5:1], 5'b00001);
      check("awfirst_wvalid", tr_w[5:1], 5'b01111);
      check("awfirst_bready", br_cnt, 1);
      check("awfirst_latency", r_lat, 6);
      check("awfirst_one_rsp", r_after_valid, 0);
      k_w_lat = 0;

      // Response back-pressure with a new command already waiting.
      @(negedge clk);
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h0; cmd_wdata = 0; cmd_wstrb = 0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
      check("stall_rsp_seen", rsp_valid, 1);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("stall_hold%0d", k),
               {rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata}, {3'b100, 2'b00, 32'h1});
         if (k == 9) begin
            rsp_ready = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'h3; cmd_wstrb = 4'hF;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      check("stall_idle_after_hs", {cmd_ready, rsp_valid}, 2'b10);
      rsp_ready = 0;
      @(negedge clk);
      check("stall_next_accepted", {cmd_ready, M_AXI_AWVALID, M_AXI_AWADDR}, {2'b01, 32'h8});
      cmd_valid = 0;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      check("stall_next_rsp", {rsp_valid, rsp_write, rsp_resp}, 4'b1100);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;

      // Reset while AW and W are both waiting.
      k_aw_lat = 100; k_w_lat = 100;
      @(negedge clk);
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
      @(negedge clk);
      cmd_valid = 0;
      repeat (2) @(negedge clk);
      check("rst_mid_pending", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWPROT, M_AXI_AWADDR},
            {2'b11, 3'b000, 32'h8});
      #2 ARESET = 1;
      #1 check("rst_mid_async", {M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, rsp_valid}, 4'b0010);
      repeat (2) @(negedge clk);
      ARESET = 0;
      k_aw_lat = 0; k_w_lat = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("rst_mid_after%0d", k), {cmd_ready, rsp_valid}, 2'b10);
      end
      do_cmd(1'b0, 32'h8, 32'h0, 4'h0);
      check("rst_mid_recover", {r_resp, r_rdata}, {2'b00, 32'h3});

`ifdef BWT_AXIL_TIMEOUT_EN
      // Slave never accepts the read address.
      k_ar_stall = 1;
      do_cmd(1'b0, 32'h4, 32'h0, 4'h0);
      check("tmo_latency", r_lat, 17);
      check("tmo_arvalid", tr_ar[17:1], 17'h0FFFF);
      check("tmo_rsp", {r_tmo, r_resp, r_rdata}, {1'b1, 2'b10, 32'h0});
      k_ar_stall = 0;
      ARESET = 1;
      repeat (2) @(negedge clk);
      ARESET = 0;
      @(negedge clk);
      check("tmo_recover_idle", {cmd_ready, rsp_timeout}, 2'b10);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation time limit reached, total=%0d", total);
      $fatal(1);
   end

endmodule
